csa_seq_mul: RTL and testbench

Sequential unsigned/signed multiplier in the multiplier library. It retires two multiplier bits per cycle into a carry-save accumulator through a row of 4:2 compressors, and resolves the sum/carry pair with one carry-propagate add. A valid/ready handshake on both sides lets it sit between pipeline stages of a datapath.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/compressor_4to2.sv | 21 ++
 rtl/csa_seq_mul.sv | 132 +++++++++++++
 tb/tb_csa_seq_mul.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential multiplier library.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RESOLVE,
      DONE
   } state_t;

   localparam int unsigned MUL_DEF_WIDTH = 8;

   function automatic int unsigned mul_iter(input int unsigned width);
      return width / 2;
   endfunction

   function automatic int unsigned mul_cnt_width(input int unsigned width);
      return $clog2(mul_iter(width));
   endfunction

   localparam int unsigned MUL_DEF_CNT_W = mul_cnt_width(MUL_DEF_WIDTH);

endpackage

// File: rtl/compressor_4to2.sv
// One bit slice of a 4:2 compressor, built from two chained full adders.
module compressor_4to2 (
   input  logic x0,
   input  logic x1,
   input  logic x2,
   input  logic x3,
   input  logic cin,
   output logic sum,
   output logic carry,
   output logic cout
);

   logic s1;

   // cout depends only on x0..x2, so chaining slices via cin never forms a ripple path
   assign s1    = x0 ^ x1 ^ x2;
   assign cout  = (x0 & x1) | (x0 & x2) | (x1 & x2);
   assign sum   = s1 ^ x3 ^ cin;
   assign carry = (s1 & x3) | (s1 & cin) | (x3 & cin);

endmodule

// File: rtl/csa_seq_mul.sv
// Radix-4 sequential multiplier with a carry-save accumulator and one final add.
// Define CSA_SEQ_MUL_SIGNED_EN for two's complement operands.
module csa_seq_mul
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned ITER = mul_iter(WIDTH);
   localparam int unsigned CW   = mul_cnt_width(WIDTH);

   state_t            state;
   logic [PW-1:0]     mcand;
   logic [WIDTH-1:0]  mplier;
   logic [PW-1:0]     sum_r;
   logic [PW-1:0]     carry_r;
   logic [CW-1:0]     cnt;

   logic [PW-1:0]     pp0;
   logic [PW-1:0]     pp1;
   logic [PW-1:0]     row_sum;
   logic [PW-1:0]     row_carry;
   logic [PW-1:0]     row_cout;
   logic [PW-1:0]     row_cin;
   logic [PW-1:0]     resolved;
   logic [WIDTH-1:0]  mag_a;
   logic [WIDTH-1:0]  mag_b;

`ifdef CSA_SEQ_MUL_SIGNED_EN
   logic neg;

   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;
`else
   assign mag_a = a;
   assign mag_b = b;
`endif

   assign pp0      = mplier[0] ? mcand : '0;
   assign pp1      = mplier[1] ? (mcand << 1) : '0;
   assign row_cin  = row_cout << 1;
   assign resolved = sum_r + carry_r;

   for (genvar i = 0; i < PW; i++) begin : g_row
      compressor_4to2 u_slice (
         .x0    (sum_r[i]),
         .x1    (carry_r[i]),
         .x2    (pp0[i]),
         .x3    (pp1[i]),
         .cin   (row_cin[i]),
         .sum   (row_sum[i]),
         .carry (row_carry[i]),
         .cout  (row_cout[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         product   <= '0;
         mcand     <= '0;
         mplier    <= '0;
         sum_r     <= '0;
         carry_r   <= '0;
         cnt       <= '0;
`ifdef CSA_SEQ_MUL_SIGNED_EN
         neg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand    <= PW'(mag_a);
                  mplier   <= mag_b;
                  sum_r    <= '0;
                  carry_r  <= '0;
                  cnt      <= '0;
`ifdef CSA_SEQ_MUL_SIGNED_EN
                  neg      <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum_r   <= row_sum;
               // slice carries carry weight 2; the bit shifted out of the top is dropped
               carry_r <= row_carry << 1;
               mcand   <= mcand << 2;
               mplier  <= mplier >> 2;
               cnt     <= cnt + CW'(1);
               if (cnt == CW'(ITER - 1)) begin
                  state <= RESOLVE;
               end
            end
            RESOLVE: begin
`ifdef CSA_SEQ_MUL_SIGNED_EN
               product <= neg ? -resolved : resolved;
`else
               product <= resolved;
`endif
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_seq_mul.sv
// Scoreboard bench for csa_seq_mul: directed spec cases plus randomized operands.
module tb_csa_seq_mul;

   localparam int unsigned W   = 8;
   localparam int unsigned PW  = 2 * W;
   localparam int unsigned LAT = W / 2 + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [PW-1:0]  product;

   int unsigned    n_checks = 0;
   int unsigned    n_pass   = 0;
   int unsigned    cyc      = 0;
   int unsigned    acc_cyc  = 0;
   int unsigned    n_acc    = 0;
   logic [PW-1:0]  sb_q[$];
   logic           prev_valid = 1'b0;
   logic           prev_hand  = 1'b0;
   logic [PW-1:0]  held       = '0;

   always #5 clk = ~clk;

   csa_seq_mul #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      int p;
`ifdef CSA_SEQ_MUL_SIGNED_EN
      p = int'($signed(x)) * int'($signed(y));
`else
      p = int'(x) * int'(y);
`endif
      return p[PW-1:0];
   endfunction

   always @(posedge clk) begin
      if (!rst && in_valid && in_ready) begin
         acc_cyc = cyc + 1;
         n_acc++;
      end
      cyc = cyc + 1;
   end

   // monitor: latency, hold-under-backpressure and scoreboard pops
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_hand  = 1'b0;
      end else begin
         if (out_valid && !prev_valid) check("latency", cyc - acc_cyc, LAT);
         if (out_valid && prev_valid && !prev_hand) check("hold_product", product, held);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("unexpected_out", out_valid, 0);
            else check("product", product, sb_q.pop_front());
         end
         prev_valid = out_valid;
         prev_hand  = out_valid && out_ready;
         held       = product;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 60) begin
         tick();
         n++;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1);
   endtask

   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [PW-1:0] exp);
      wait_ready();
      in_valid = 1'b1;
      a = x;
      b = y;
      sb_q.push_back(exp);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input bit rand_bp);
      int n = 0;
      while ((sb_q.size() != 0 || !in_ready) && n < 100) begin
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      out_ready = 1'b1;
      if (n >= 100) check("drain_timeout", sb_q.size(), 0);
   endtask

   logic [W-1:0]  da[4];
   logic [W-1:0]  db[4];
   logic [PW-1:0] dp[4];

   initial begin
      int unsigned acc0;
      logic [W-1:0] ra, rb;

`ifdef CSA_SEQ_MUL_SIGNED_EN
      da = '{8'hFD, 8'h80, 8'h7F, 8'h03};
      db = '{8'h05, 8'h80, 8'h80, 8'h07};
      dp = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0015};
`else
      da = '{8'hFF, 8'h00, 8'hFF, 8'h03};
      db = '{8'hFF, 8'hA5, 8'h01, 8'h07};
      dp = '{16'hFE01, 16'h0000, 16'h00FF, 16'h0015};
`endif

      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_product", product, 0);

      for (int i = 0; i < 4; i++) begin
         do_op(da[i], db[i], dp[i]);
         wait_drain(1'b0);
      end

      // backpressure: result held while out_ready is low
      out_ready = 1'b0;
      do_op(8'h12, 8'h34, 16'h03A8);
      for (int n = 0; n < 20 && !out_valid; n++) tick();
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", out_valid, 1);
         check("bp_product", product, 16'h03A8);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);

      // inputs ignored outside IDLE
      out_ready = 1'b0;
      wait_ready();
      acc0 = n_acc;
      in_valid = 1'b1;
      a = 8'h5A;
      b = 8'h3C;
      sb_q.push_back(ref_mul(8'h5A, 8'h3C));
      tick();
      for (int i = 0; i < 10; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         tick();
      end
      check("ignore_accepts", n_acc, acc0 + 1);
      check("ignore_in_ready", in_ready, 0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain(1'b0);

      // reset mid-RUN aborts the operation
      do_op(8'h0F, 8'h0F, 16'h00E1);
      tick();
      rst = 1'b1;
      sb_q.delete();
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      tick();
      tick();
      check("rst_hold_in_ready", in_ready, 1);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("abort_no_valid", out_valid, 0);
         tick();
      end
      check("abort_in_ready", in_ready, 1);
      do_op(8'h03, 8'h07, 16'h0015);
      wait_drain(1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i == 0) ra = 8'h80;
         if (i == 1) rb = 8'h7F;
         do_op(ra, rb, ref_mul(ra, rb));
         wait_drain(i % 2 == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
